// File: rtl/bnn_pkg.sv
// Shared types and defaults for the binarized output-layer blocks.
// The FSM state enum, the layer-size defaults and the popcount width helper live here.
package bnn_pkg;

    localparam int BNN_IN_W        = 256;
    localparam int BNN_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Width needed to hold a count of 0..w set bits.
    function automatic int popcnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-popcount: counts bit positions where the two operands agree.
// The hidden binarized layers use this same unit.
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter int IN_W  = BNN_IN_W,
    parameter int CNT_W = popcnt_width(IN_W)
) (
    input  logic [IN_W-1:0]  i_a,
    input  logic [IN_W-1:0]  i_b,
    output logic [CNT_W-1:0] o_count
);

    logic [IN_W-1:0] w_xnor;

    assign w_xnor = ~(i_a ^ i_b);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < IN_W; i++) begin
            o_count = o_count + CNT_W'(w_xnor[i]);
        end
    end

endmodule

// File: rtl/bnn_argmax_sched.sv
// Output-layer scheduler: streams weight rows through one XNOR-popcount unit and keeps the argmax.
// Optional per-row score debug stream is enabled by defining SCORE_STREAM_EN.
module bnn_argmax_sched
    import bnn_pkg::*;
#(
    parameter int IN_W        = BNN_IN_W,
    parameter int NUM_CLASSES = BNN_NUM_CLASSES,
    parameter int CNT_W       = popcnt_width(IN_W),
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             rom_en,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [IN_W-1:0]  rom_data,
    output logic [IDX_W-1:0] out_class,
    output logic [CNT_W-1:0] out_score,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SCORE_STREAM_EN
    output logic             score_valid,
    output logic [IDX_W-1:0] score_idx,
    output logic [CNT_W-1:0] score_val,
`endif
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;

    logic [IN_W-1:0]  r_feat;
    logic [IDX_W-1:0] r_issue_idx;
    logic             r_score_pending;
    logic [IDX_W-1:0] r_score_idx;
    logic [CNT_W-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_class;
    logic [CNT_W-1:0] r_out_score;

    logic [CNT_W-1:0] w_score;
    logic             w_accept;
    logic             w_last_issue;
    logic             w_take;

    xnor_popcount #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .i_a     (rom_data),
        .i_b     (r_feat),
        .o_count (w_score)
    );

    assign w_accept     = in_valid && in_ready;
    assign w_last_issue = (r_issue_idx == IDX_W'(NUM_CLASSES - 1));
    // Row 0 always seeds the maximum; strict compare keeps the lower index on ties.
    assign w_take       = r_score_pending && ((r_score_idx == '0) || (w_score > r_best));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   if (w_last_issue) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    if (r_out_valid && out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        rom_en   = 1'b0;
        rom_addr = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ISSUE: begin
                rom_en   = 1'b1;
                rom_addr = r_issue_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_feat          <= '0;
            r_issue_idx     <= '0;
            r_score_pending <= 1'b0;
            r_score_idx     <= '0;
            r_best          <= '0;
            r_best_idx      <= '0;
            r_out_valid     <= 1'b0;
            r_out_class     <= '0;
            r_out_score     <= '0;
        end else begin
            r_score_pending <= rom_en;
            r_score_idx     <= rom_addr;

            if (w_accept) begin
                r_feat      <= in_data;
                r_issue_idx <= '0;
                r_best      <= '0;
                r_best_idx  <= '0;
            end else begin
                if (r_state == ISSUE && !w_last_issue) begin
                    r_issue_idx <= r_issue_idx + IDX_W'(1);
                end
                if (w_take) begin
                    r_best     <= w_score;
                    r_best_idx <= r_score_idx;
                end
            end

            // Result is latched once on entering DONE and then held until taken.
            if (r_state == DONE && !r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_class <= r_best_idx;
                r_out_score <= r_best;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_score = r_out_score;

`ifdef SCORE_STREAM_EN
    assign score_valid = r_score_pending;
    assign score_idx   = r_score_idx;
    assign score_val   = w_score;
`endif

endmodule

// File: tb/tb_bnn_argmax_sched.sv
// Self-checking bench for bnn_argmax_sched with a registered ROM model and an expected-result queue.
// Define SCORE_STREAM_EN to also check the per-row score stream.
module tb_bnn_argmax_sched;

    localparam int IN_W        = 256;
    localparam int NUM_CLASSES = 10;
    localparam int CNT_W       = 9;
    localparam int IDX_W       = 4;

    typedef struct {
        logic [IDX_W-1:0] cls;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             rom_en;
    logic [IDX_W-1:0] rom_addr;
    logic [IN_W-1:0]  rom_data = '0;
    logic [IDX_W-1:0] out_class;
    logic [CNT_W-1:0] out_score;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;
`ifdef SCORE_STREAM_EN
    logic             score_valid;
    logic [IDX_W-1:0] score_idx;
    logic [CNT_W-1:0] score_val;
`endif

    logic [IN_W-1:0]  rom_mem [NUM_CLASSES];
    exp_t             expq [$];
    int               vectors = 0;
    int               miscompares = 0;

    bnn_argmax_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_class (out_class),
        .out_score (out_score),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SCORE_STREAM_EN
        .score_valid (score_valid),
        .score_idx   (score_idx),
        .score_val   (score_val),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single-port ROM: data appears exactly one cycle after the enable.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [IN_W-1:0] ones_vec(input int n);
        logic [IN_W-1:0] v;
        v = '0;
        for (int i = 0; i < IN_W; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference argmax: first row seeds, strictly greater wins, so ties keep the lower index.
    function automatic exp_t ref_model(input logic [IN_W-1:0] f);
        exp_t e;
        int   best;
        int   s;
        best = -1;
        e.cls = '0;
        e.sc  = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            s = $countones(~(f ^ rom_mem[k]));
            if (k == 0 || s > best) begin
                best  = s;
                e.cls = IDX_W'(k);
                e.sc  = CNT_W'(s);
            end
        end
        return e;
    endfunction

    task automatic fill_rom_random();
        for (int k = 0; k < NUM_CLASSES; k++) rom_mem[k] = rand_vec();
    endtask

    // Presents a vector, waits for acceptance, and queues its expected result.
    task automatic drive_vector(input logic [IN_W-1:0] f, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_data  = f;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            expq.push_back(ref_model(f));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the accept edge; counts edges until out_valid is seen.
    task automatic wait_valid(input int maxc, output int cycles);
        cycles = 0;
        while (cycles <= maxc) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors += 7;
        if (in_ready !== 1'b1)  begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        if (rom_en !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_rom_en: got %b want 0", rom_en); end
        if (rom_addr !== '0)    begin miscompares++; $display("[TB] FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        if (out_class !== '0)   begin miscompares++; $display("[TB] FAIL reset_out_class: got %0d want 0", out_class); end
        if (out_score !== '0)   begin miscompares++; $display("[TB] FAIL reset_out_score: got %0d want 0", out_score); end
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_distinct();
        bit   ok;
        int   cycles;
        int   nissue;
        exp_t e;
        for (int k = 0; k < NUM_CLASSES; k++) rom_mem[k] = ones_vec(20 * k + 5);
        drive_vector(ones_vec(IN_W), ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL distinct_accept: got not accepted want accepted"); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL distinct_in_ready_busy: got %b want 0", in_ready); end
        cycles = 0;
        nissue = 0;
        while (cycles < 40) begin
            if (rom_en) begin
                vectors++;
                if (rom_addr !== IDX_W'(nissue)) begin
                    miscompares++;
                    $display("[TB] FAIL distinct_rom_addr: got %0d want %0d", rom_addr, nissue);
                end
                nissue++;
            end
            if (out_valid) break;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        vectors += 3;
        if (nissue != NUM_CLASSES) begin miscompares++; $display("[TB] FAIL distinct_rom_reads: got %0d want %0d", nissue, NUM_CLASSES); end
        if (cycles != NUM_CLASSES + 2) begin miscompares++; $display("[TB] FAIL distinct_latency: got %0d want %0d", cycles, NUM_CLASSES + 2); end
        if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL distinct_out_valid: got %b want 1", out_valid); end
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL distinct_queue: got empty want one entry");
        end else begin
            e = expq.pop_front();
            if (out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL distinct_result: got class %0d score %0d want class %0d score %0d", out_class, out_score, e.cls, e.sc);
            end
        end
        @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL distinct_valid_drop: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL distinct_in_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_tie();
        bit              ok;
        int              cycles;
        exp_t            e;
        int              flips [NUM_CLASSES] = '{100, 90, 80, 56, 70, 60, 65, 56, 99, 120};
        logic [IN_W-1:0] f;
        f = rand_vec();
        for (int k = 0; k < NUM_CLASSES; k++) rom_mem[k] = f ^ ones_vec(flips[k]);
        drive_vector(f, ok);
        wait_valid(40, cycles);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_out_valid: got %b want 1 after %0d cycles", out_valid, cycles); end
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL tie_queue: got empty want one entry");
        end else begin
            e = expq.pop_front();
            if (out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL tie_result: got class %0d score %0d want class %0d score %0d", out_class, out_score, e.cls, e.sc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   cycles;
        exp_t e;
        fill_rom_random();
        out_ready = 1'b0;
        drive_vector(rand_vec(), ok);
        wait_valid(40, cycles);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_out_valid: got %b want 1", out_valid); end
        e.cls = '0;
        e.sc  = '0;
        if (expq.size() != 0) e = expq.pop_front();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL bp_hold: got valid %b ready %b class %0d score %0d want 1 0 %0d %0d",
                         out_valid, in_ready, out_class, out_score, e.cls, e.sc);
            end
            if (i < 5) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_busy_input();
        bit   ok;
        bit   got_a;
        int   k;
        exp_t e;
        fill_rom_random();
        out_ready = 1'b1;
        drive_vector(rand_vec(), ok);
        in_data  = rom_mem[2];
        in_valid = 1'b1;
        got_a    = 1'b0;
        k        = 0;
        while (k < 40 && !in_ready) begin
            if (out_valid && !got_a) begin
                got_a = 1'b1;
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL busy_first_queue: got empty want one entry");
                end else begin
                    e = expq.pop_front();
                    if (out_class !== e.cls || out_score !== e.sc) begin
                        miscompares++;
                        $display("[TB] FAIL busy_first_result: got class %0d score %0d want class %0d score %0d", out_class, out_score, e.cls, e.sc);
                    end
                end
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        vectors += 2;
        if (!got_a) begin miscompares++; $display("[TB] FAIL busy_first_seen: got no result want result before re-accept"); end
        if (k != NUM_CLASSES + 3) begin miscompares++; $display("[TB] FAIL busy_reaccept_cycle: got %0d want %0d", k, NUM_CLASSES + 3); end
        @(posedge clk);
        expq.push_back(ref_model(rom_mem[2]));
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(40, k);
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL busy_second_queue: got empty want one entry");
        end else begin
            e = expq.pop_front();
            if (out_valid !== 1'b1 || out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL busy_second_result: got valid %b class %0d score %0d want 1 class %0d score %0d", out_valid, out_class, out_score, e.cls, e.sc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   seen;
        int   cycles;
        exp_t e;
        fill_rom_random();
        drive_vector(rom_mem[1], ok);
        cycles = 0;
        while (cycles < 20 && !(rom_en && rom_addr == IDX_W'(4))) begin
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (!(rom_en && rom_addr == IDX_W'(4))) begin miscompares++; $display("[TB] FAIL rstmid_reach_idx4: got en %b addr %0d want 1 4", rom_en, rom_addr); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if (expq.size() != 0) void'(expq.pop_back());
        vectors += 3;
        if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_rom_en: got %b want 0", rom_en); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || rom_en) seen = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (seen) begin miscompares++; $display("[TB] FAIL rstmid_quiet: got activity want none after reset"); end
        fill_rom_random();
        drive_vector(rand_vec(), ok);
        wait_valid(40, cycles);
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_queue: got empty want one entry");
        end else begin
            e = expq.pop_front();
            if (out_valid !== 1'b1 || out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL rstmid_result: got valid %b class %0d score %0d want 1 class %0d score %0d", out_valid, out_class, out_score, e.cls, e.sc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef SCORE_STREAM_EN
    task automatic test_score_stream();
        bit              ok;
        int              n;
        int              c;
        exp_t            e;
        logic [IN_W-1:0] f;
        fill_rom_random();
        f = rand_vec();
        drive_vector(f, ok);
        n = 0;
        c = 0;
        while (c < 40) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (score_valid) begin
                vectors++;
                if (n >= NUM_CLASSES) begin
                    miscompares++;
                    $display("[TB] FAIL stream_extra_pulse: got pulse %0d want at most %0d", n, NUM_CLASSES);
                end else if (score_idx !== IDX_W'(n) || score_val !== CNT_W'($countones(~(f ^ rom_mem[n])))) begin
                    miscompares++;
                    $display("[TB] FAIL stream_row: got idx %0d val %0d want idx %0d val %0d", score_idx, score_val, n, $countones(~(f ^ rom_mem[n])));
                end
                n++;
            end
            if (out_valid) break;
        end
        vectors += 2;
        if (n != NUM_CLASSES) begin miscompares++; $display("[TB] FAIL stream_count: got %0d want %0d", n, NUM_CLASSES); end
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL stream_queue: got empty want one entry");
        end else begin
            e = expq.pop_front();
            if (out_class !== e.cls || out_score !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL stream_result: got class %0d score %0d want class %0d score %0d", out_class, out_score, e.cls, e.sc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_distinct();
        test_tie();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
`ifdef SCORE_STREAM_EN
        test_score_stream();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
